stepper_ramp_gen: RTL and testbench

- Step-rate / motion-profile generator directly upstream of the stepper phase sequencer FSM.
- Takes a move command (step count, direction, mode, timing) and emits one-cycle step ticks on a trapezoidal profile: accelerate, cruise, decelerate.
- The sequencer advances its coil phase on each o_step_tick and uses the latched direction and mode.
- Command fields arrive from the AXI4-Lite register block.

---
 rtl/stepper_pkg.sv | 26 ++
 rtl/stepper_ramp_gen_if.sv | 36 +++
 rtl/step_timer.sv | 25 ++
 rtl/stepper_ramp_gen.sv | 121 ++++++++++++
 tb/tb_stepper_ramp_gen.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper motion path: mode encodings, ramp
// generator state encoding and default datapath widths.
package stepper_pkg;

    localparam int unsigned PER_W_DEF  = 24;
    localparam int unsigned STEP_W_DEF = 14;

    typedef enum logic [1:0] {
        MODE_IDLE      = 2'd0,
        MODE_FULL_STEP = 2'd1,
        MODE_HALF_STEP = 2'd2
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEL,
        ST_CRUISE,
        ST_DECEL,
        ST_DONE
    } ramp_state_e;

    function automatic logic mode_valid(input logic [1:0] mode);
        return (mode == MODE_FULL_STEP) || (mode == MODE_HALF_STEP);
    endfunction

endpackage

// File: rtl/stepper_ramp_gen_if.sv
// Command and status bundle between the register block (master) and the
// ramp generator (slave).
interface stepper_ramp_gen_if
    import stepper_pkg::*;
#(
    parameter int unsigned PER_W  = PER_W_DEF,
    parameter int unsigned STEP_W = STEP_W_DEF
);
    logic              i_start;
    logic              i_stop;
    logic              i_dir;
    logic [1:0]        i_mode;
    logic [STEP_W-1:0] i_step_total;
    logic [PER_W-1:0]  i_period_start;
    logic [PER_W-1:0]  i_period_min;
    logic [PER_W-1:0]  i_period_dec;

    logic              o_step_tick;
    logic              o_dir;
    logic [1:0]        o_mode;
    logic              o_busy;
    logic              o_done;
    logic [STEP_W-1:0] o_step_cnt;

    modport master (
        output i_start, i_stop, i_dir, i_mode, i_step_total,
               i_period_start, i_period_min, i_period_dec,
        input  o_step_tick, o_dir, o_mode, o_busy, o_done, o_step_cnt
    );

    modport slave (
        input  i_start, i_stop, i_dir, i_mode, i_step_total,
               i_period_start, i_period_min, i_period_dec,
        output o_step_tick, o_dir, o_mode, o_busy, o_done, o_step_cnt
    );
endinterface

// File: rtl/step_timer.sv
// Free-running interval counter: tick is high in the cycle where the count
// reaches period-1; a low enable holds the count at zero.
module step_timer #(
    parameter int unsigned PER_W = 24
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             enable,
    input  logic [PER_W-1:0] period,
    output logic             tick
);
    logic [PER_W-1:0] timer;

    assign tick = enable && (timer == period - PER_W'(1));

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            timer <= '0;
        end else if (!enable || tick) begin
            timer <= '0;
        end else begin
            timer <= timer + PER_W'(1);
        end
    end
endmodule

// File: rtl/stepper_ramp_gen.sv
// Trapezoidal step-rate generator: accelerate, cruise, decelerate, emitting
// one-cycle step ticks for the downstream phase sequencer.
module stepper_ramp_gen
    import stepper_pkg::*;
#(
    parameter int unsigned PER_W  = PER_W_DEF,
    parameter int unsigned STEP_W = STEP_W_DEF
) (
    input logic               i_clk,
    input logic               i_reset,
    stepper_ramp_gen_if.slave bus
);
    ramp_state_e       state, state_next;
    logic [PER_W-1:0]  per_start, per_min, per_dec, period;
    logic [STEP_W-1:0] step_total, step_cnt, acc_cnt;
    logic              dir_q;
    logic [1:0]        mode_q;

    logic              timer_en, tick, busy, done;
    logic              start_ok;
    logic [PER_W-1:0]  start_clamp, min_clamp, inc_per;
    logic [PER_W:0]    dec_sum, inc_sum;
    logic [STEP_W-1:0] new_cnt, rem, new_acc;

    step_timer #(.PER_W(PER_W)) u_timer (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .enable (timer_en),
        .period (period),
        .tick   (tick)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        start_ok    = bus.i_start && mode_valid(bus.i_mode) && (bus.i_step_total != '0);
        start_clamp = (bus.i_period_start < PER_W'(2)) ? PER_W'(2) : bus.i_period_start;
        min_clamp   = (bus.i_period_min < PER_W'(2)) ? PER_W'(2) : bus.i_period_min;
        if (min_clamp > start_clamp) min_clamp = start_clamp;

        new_cnt = step_cnt + STEP_W'(1);
        rem     = step_total - new_cnt;
        new_acc = acc_cnt + STEP_W'(1);
        // Widened sums keep the ramp compares free of underflow/overflow.
        dec_sum = {1'b0, per_min} + {1'b0, per_dec};
        inc_sum = {1'b0, period} + {1'b0, per_dec};
        inc_per = (inc_sum > {1'b0, per_start}) ? per_start : inc_sum[PER_W-1:0];

        state_next = state;
        case (state)
            ST_IDLE:   if (bus.i_start) state_next = start_ok ? ST_ACCEL : ST_DONE;
            ST_ACCEL:  if (tick) begin
                           if (rem == '0)                        state_next = ST_DONE;
                           else if (rem <= new_acc)              state_next = ST_DECEL;
                           else if ({1'b0, period} <= dec_sum)   state_next = ST_CRUISE;
                       end
            ST_CRUISE: if (tick) begin
                           if (rem == '0)            state_next = ST_DONE;
                           else if (rem <= acc_cnt)  state_next = ST_DECEL;
                       end
            ST_DECEL:  if (tick && rem == '0) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        if (busy && bus.i_stop) state_next = ST_DONE;
    end

    always_comb begin
        busy     = (state == ST_ACCEL) || (state == ST_CRUISE) || (state == ST_DECEL);
        done     = (state == ST_DONE);
        timer_en = busy;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            per_start  <= '0;
            per_min    <= '0;
            per_dec    <= '0;
            period     <= '0;
            step_total <= '0;
            step_cnt   <= '0;
            acc_cnt    <= '0;
            dir_q      <= 1'b0;
            mode_q     <= '0;
        end else if (state == ST_IDLE) begin
            if (start_ok) begin
                per_start  <= start_clamp;
                per_min    <= min_clamp;
                per_dec    <= bus.i_period_dec;
                period     <= start_clamp;
                step_total <= bus.i_step_total;
                step_cnt   <= '0;
                acc_cnt    <= '0;
                dir_q      <= bus.i_dir;
                mode_q     <= bus.i_mode;
            end
        end else if (busy && tick) begin
            step_cnt <= new_cnt;
            case (state)
                ST_ACCEL: begin
                    acc_cnt <= new_acc;
                    if (rem > new_acc)
                        period <= ({1'b0, period} <= dec_sum) ? per_min : period - per_dec;
                end
                ST_CRUISE: if (rem <= acc_cnt) period <= inc_per;
                ST_DECEL:  period <= inc_per;
                default:   ;
            endcase
        end
    end

    assign bus.o_step_tick = tick;
    assign bus.o_busy      = busy;
    assign bus.o_done      = done;
    assign bus.o_dir       = dir_q;
    assign bus.o_mode      = mode_q;
    assign bus.o_step_cnt  = step_cnt;
endmodule

// File: tb/tb_stepper_ramp_gen.sv
// Directed bench for stepper_ramp_gen: trapezoid, short move, abort,
// degenerate starts, reset mid-move and period clamping.
module tb_stepper_ramp_gen;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    stepper_ramp_gen_if #(.PER_W(24), .STEP_W(14)) bus ();

    stepper_ramp_gen #(.PER_W(24), .STEP_W(14)) dut (
        .i_clk  (clk),
        .i_reset(rst_n),
        .bus    (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ntick, done_cyc, last, c0;
    int got_iv [0:15];
    int exp_trap  [0:7] = '{10, 8, 6, 4, 4, 6, 8, 10};
    int exp_short [0:3] = '{10, 8, 8, 10};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_move(input logic dir, input logic [1:0] mode, input logic [13:0] total,
                              input logic [23:0] ps, input logic [23:0] pm, input logic [23:0] pd);
        bus.i_dir          = dir;
        bus.i_mode         = mode;
        bus.i_step_total   = total;
        bus.i_period_start = ps;
        bus.i_period_min   = pm;
        bus.i_period_dec   = pd;
        bus.i_start        = 1'b1;
        step();
        bus.i_start        = 1'b0;
    endtask

    // Records tick intervals until o_done or the cycle budget runs out;
    // stop_at > 0 raises i_stop for one cycle after that many ticks.
    task automatic collect(input int last0, input int stop_at, input int budget);
        logic arm;
        arm      = 1'b0;
        ntick    = 0;
        done_cyc = -1;
        last     = last0;
        for (int k = 0; k < budget; k++) begin
            bus.i_stop = arm;
            arm        = 1'b0;
            if (bus.o_step_tick) begin
                if (ntick < 16) got_iv[ntick] = cyc - last;
                last = cyc;
                ntick++;
                if (ntick == stop_at) arm = 1'b1;
            end
            if (bus.o_done) begin
                done_cyc = cyc;
                break;
            end
            step();
        end
        bus.i_stop = 1'b0;
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.i_start        = 1'b0;
        bus.i_stop         = 1'b0;
        bus.i_dir          = 1'b0;
        bus.i_mode         = 2'd0;
        bus.i_step_total   = '0;
        bus.i_period_start = '0;
        bus.i_period_min   = '0;
        bus.i_period_dec   = '0;
        repeat (3) step();

        chk("rst_busy", bus.o_busy, 0);
        chk("rst_done", bus.o_done, 0);
        chk("rst_tick", bus.o_step_tick, 0);
        chk("rst_cnt",  bus.o_step_cnt, 0);
        chk("rst_dir",  bus.o_dir, 0);
        chk("rst_mode", bus.o_mode, 0);
        rst_n = 1'b1;
        step();

        // Trapezoid
        start_move(1'b1, 2'd1, 14'd8, 24'd10, 24'd4, 24'd2);
        c0 = cyc;
        chk("trap_busy", bus.o_busy, 1);
        chk("trap_dir",  bus.o_dir, 1);
        chk("trap_mode", bus.o_mode, 1);
        collect(c0 - 1, 0, 200);
        chk("trap_nticks", ntick, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("trap_iv%0d", i), got_iv[i], exp_trap[i]);
        chk("trap_done_lat", done_cyc, last + 1);
        chk("trap_cnt", bus.o_step_cnt, 8);
        chk("trap_busy_end", bus.o_busy, 0);
        step();
        chk("trap_done_1cyc", bus.o_done, 0);
        chk("trap_dir_hold", bus.o_dir, 1);

        // Short move, with a second start injected mid-move
        start_move(1'b1, 2'd1, 14'd4, 24'd10, 24'd4, 24'd2);
        c0 = cyc;
        step();
        bus.i_mode       = 2'd2;
        bus.i_dir        = 1'b0;
        bus.i_step_total = 14'd50;
        bus.i_start      = 1'b1;
        step();
        bus.i_start      = 1'b0;
        collect(c0 - 1, 0, 200);
        chk("short_nticks", ntick, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("short_iv%0d", i), got_iv[i], exp_short[i]);
        chk("short_cnt", bus.o_step_cnt, 4);
        chk("short_mode_kept", bus.o_mode, 1);
        chk("short_dir_kept", bus.o_dir, 1);
        step();

        // Abort one cycle after the 3rd tick
        start_move(1'b1, 2'd1, 14'd8, 24'd10, 24'd4, 24'd2);
        c0 = cyc;
        collect(c0 - 1, 3, 200);
        chk("abort_nticks", ntick, 3);
        chk("abort_done_lat", done_cyc, last + 2);
        chk("abort_cnt", bus.o_step_cnt, 3);
        chk("abort_busy", bus.o_busy, 0);
        step();
        chk("abort_done_1cyc", bus.o_done, 0);

        // Degenerate starts: zero steps, then mode 0
        start_move(1'b0, 2'd1, 14'd0, 24'd10, 24'd4, 24'd2);
        chk("deg0_done", bus.o_done, 1);
        chk("deg0_busy", bus.o_busy, 0);
        chk("deg0_tick", bus.o_step_tick, 0);
        step();
        chk("deg0_done_end", bus.o_done, 0);
        start_move(1'b0, 2'd0, 14'd5, 24'd10, 24'd4, 24'd2);
        chk("degm_done", bus.o_done, 1);
        chk("degm_busy", bus.o_busy, 0);
        step();
        chk("degm_done_end", bus.o_done, 0);
        chk("deg_cnt_hold", bus.o_step_cnt, 3);
        chk("deg_mode_hold", bus.o_mode, 1);

        // Reset after the 2nd tick
        start_move(1'b1, 2'd2, 14'd8, 24'd10, 24'd4, 24'd2);
        ntick = 0;
        for (int k = 0; k < 100; k++) begin
            if (bus.o_step_tick) ntick++;
            if (ntick == 2) break;
            step();
        end
        chk("rmid_nticks", ntick, 2);
        rst_n = 1'b0;
        step();
        chk("rmid_busy", bus.o_busy, 0);
        chk("rmid_done", bus.o_done, 0);
        chk("rmid_tick", bus.o_step_tick, 0);
        chk("rmid_cnt",  bus.o_step_cnt, 0);
        chk("rmid_dir",  bus.o_dir, 0);
        chk("rmid_mode", bus.o_mode, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("rmid_nodone%0d", k), bus.o_done, 0);
        end

        // Clamping of start/min periods
        start_move(1'b0, 2'd2, 14'd3, 24'd1, 24'd0, 24'd5);
        c0 = cyc;
        collect(c0 - 1, 0, 100);
        chk("clamp_nticks", ntick, 3);
        for (int i = 0; i < 3; i++) chk($sformatf("clamp_iv%0d", i), got_iv[i], 2);
        chk("clamp_done_lat", done_cyc, last + 1);
        chk("clamp_cnt", bus.o_step_cnt, 3);
        chk("clamp_mode", bus.o_mode, 2);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
